// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side types and program-window constants for the MIPS fetch path.
// Also consumed by the program-memory address decoder.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PROG_BASE_ADDR = 32'h0000_31B0;
  localparam logic [31:0] PROG_END_ADDR  = 32'h0000_35AF;
  localparam logic [31:0] PROG_LAST_WORD = PROG_END_ADDR - 32'd3;

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check and word alignment for one redirect target.
// With FETCH_ALIGN_CHECK_EN defined, misaligned targets are illegal; otherwise the low bits are cleared.
module pc_target_check #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_31B0,
  parameter logic [ADDR_W-1:0] LAST_WORD = 32'h0000_35AC
) (
  input  logic [ADDR_W-1:0] target,
  output logic              legal,
  output logic [ADDR_W-1:0] aligned
);

  logic in_range;

`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    aligned  = target;
    in_range = (target >= BASE_ADDR) && (target <= LAST_WORD);
    legal    = in_range && (target[1:0] == 2'b00);
  end
`else
  // Low bits are dropped before the range check, so misalignment alone never faults.
  always_comb begin
    aligned  = target & ~ADDR_W'(3);
    in_range = (aligned >= BASE_ADDR) && (aligned <= LAST_WORD);
    legal    = in_range;
  end
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer: BOOT -> RUN, sequential fetch with wrap, stall, jump/branch redirect.
// Optional build macro FETCH_ALIGN_CHECK_EN makes misaligned redirect targets fault (see pc_target_check).
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = PROG_BASE_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR  = PROG_END_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              wrapped,
  output logic              fault,
  output fetch_state_t      fetch_state
);

  localparam logic [ADDR_W-1:0] LAST_WORD = END_ADDR - ADDR_W'(3);

  // fetch_valid qualifies pc_out for the current cycle only; the consumer never
  // back-pressures it, it holds the PC by raising stall instead.

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;
  logic              jump_legal, branch_legal;
  logic [ADDR_W-1:0] jump_aligned, branch_aligned;
  logic [ADDR_W-1:0] seq_pc;
  logic              at_last;

  pc_target_check #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .LAST_WORD(LAST_WORD)
  ) u_jump_check (
    .target (jump_target),
    .legal  (jump_legal),
    .aligned(jump_aligned)
  );

  pc_target_check #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .LAST_WORD(LAST_WORD)
  ) u_branch_check (
    .target (branch_target),
    .legal  (branch_legal),
    .aligned(branch_aligned)
  );

  assign at_last = (pc_q == LAST_WORD);
  assign seq_pc  = at_last ? BASE_ADDR : (pc_q + ADDR_W'(4));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= BASE_ADDR;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Targets are not evaluated while stalled, so a stalled illegal redirect cannot fault.
        if (stall) begin
          pc_d = pc_q;
        end else if (jump) begin
          if (jump_legal) pc_d = jump_aligned;
          else            state_d = FAULT;
        end else if (branch_taken) begin
          if (branch_legal) pc_d = branch_aligned;
          else              state_d = FAULT;
        end else begin
          pc_d   = seq_pc;
          wrap_d = at_last;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  assign pc_out      = pc_q;
  assign pc_plus4    = seq_pc;
  assign fetch_valid = (state_q == RUN);
  assign fault       = (state_q == FAULT);
  assign wrapped     = wrap_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: driver pushes hand-computed per-cycle outputs, monitor pops and compares.
module tb_pc_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int W = 67;
  localparam logic [31:0] BASE = 32'h0000_31B0;
  localparam logic [31:0] LAST = 32'h0000_35AC;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         jump;
  logic [31:0]  jump_target;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic [31:0]  pc_out;
  logic [31:0]  pc_plus4;
  logic         fetch_valid;
  logic         wrapped;
  logic         fault;
  fetch_state_t fetch_state;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;
  int cyc_n;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .wrapped      (wrapped),
    .fault        (fault),
    .fetch_state  (fetch_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // driver: apply inputs just after the edge and push the outputs expected in this cycle
  task automatic drive(input logic r, input logic s, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt,
                       input logic [31:0] epc, input logic ev, input logic ew, input logic ef);
    logic [31:0] ep4;
    @(posedge clk);
    #1;
    rst           = r;
    stall         = s;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_target = bt;
    ep4 = (epc == LAST) ? BASE : epc + 32'd4;
    exp_q.push_back({ef, ew, ev, ep4, epc});
  endtask

  task automatic idle(input logic [31:0] epc, input logic ev, input logic ew, input logic ef);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, ev, ew, ef);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    cyc_n = cyc_n + 1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act   = {fault, wrapped, fetch_valid, pc_plus4, pc_out};
      total = total + 1;
      if (act !== exp_v) begin
        bad = bad + 1;
        $display("FAIL cycle%0d {fault,wrapped,valid,pc_plus4,pc_out}: got %h required %h",
                 cyc_n, act, exp_v);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc_n = 0;
    rst = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = 32'h0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // held in reset, then release: BOOT cycle, then sequential fetch
    drive(1'b0, 0, 0, 32'h0, 0, 32'h0, BASE, 0, 0, 0);
    drive(1'b0, 0, 0, 32'h0, 0, 32'h0, BASE, 0, 0, 0);
    drive(1'b1, 0, 0, 32'h0, 0, 32'h0, BASE, 0, 0, 0);
    for (int i = 0; i < 256; i++) idle(BASE + 32'(4 * i), 1, 0, 0);
    // wrapped pulses once after 0x35AC, jump to 0x3200 from 0x31B4
    idle(BASE, 1, 1, 0);
    drive(1'b1, 0, 1, 32'h3200, 0, 32'h0, 32'h31B4, 1, 0, 0);

    // stall three cycles with a pending jump to 0x3300
    drive(1'b1, 1, 1, 32'h3300, 0, 32'h0, 32'h3200, 1, 0, 0);
    drive(1'b1, 1, 1, 32'h3300, 0, 32'h0, 32'h3200, 1, 0, 0);
    drive(1'b1, 1, 1, 32'h3300, 0, 32'h0, 32'h3200, 1, 0, 0);
    drive(1'b1, 0, 1, 32'h3300, 0, 32'h0, 32'h3200, 1, 0, 0);
    // jump beats branch, then a plain branch
    drive(1'b1, 0, 1, 32'h3400, 1, 32'h3280, 32'h3300, 1, 0, 0);
    drive(1'b1, 0, 0, 32'h0, 1, 32'h3280, 32'h3400, 1, 0, 0);
    // misaligned jump target 0x3202
    drive(1'b1, 0, 1, 32'h3202, 0, 32'h0, 32'h3280, 1, 0, 0);

`ifdef FETCH_ALIGN_CHECK_EN
    drive(1'b1, 1, 0, 32'h0, 1, 32'h35B0, 32'h3280, 0, 0, 1);
    drive(1'b1, 0, 0, 32'h0, 1, 32'h35B0, 32'h3280, 0, 0, 1);
    drive(1'b1, 0, 1, 32'h3300, 0, 32'h0, 32'h3280, 0, 0, 1);
    idle(32'h3280, 0, 0, 1);
`else
    // stalled illegal branch is ignored, then the same branch unstalled faults
    drive(1'b1, 1, 0, 32'h0, 1, 32'h35B0, 32'h3200, 1, 0, 0);
    drive(1'b1, 0, 0, 32'h0, 1, 32'h35B0, 32'h3200, 1, 0, 0);
    drive(1'b1, 0, 1, 32'h3300, 0, 32'h0, 32'h3200, 0, 0, 1);
    idle(32'h3200, 0, 0, 1);
`endif

    // asynchronous reset from FAULT takes effect within the cycle
    drive(1'b0, 0, 0, 32'h0, 0, 32'h0, BASE, 0, 0, 0);
    drive(1'b1, 0, 0, 32'h0, 0, 32'h0, BASE, 0, 0, 0);
    // jump to the last legal word, wrap from there, then jump below the window
    drive(1'b1, 0, 1, LAST, 0, 32'h0, BASE, 1, 0, 0);
    idle(LAST, 1, 0, 0);
    drive(1'b1, 0, 1, 32'h31AC, 0, 32'h0, BASE, 1, 1, 0);
    idle(BASE, 0, 0, 1);
    idle(BASE, 0, 0, 1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program counter and fetch sequencer for the MIPS CPU.
- Generates the 32-bit instruction address that drives the program-memory address decoder directly downstream. That decoder's address_in is fed by this block's pc_out.
- Keeps the PC inside the program-memory window 0x31B0..0x35AF.
- Handles sequential increment, stall, and branch/jump redirection.
- Flags an out-of-window or misaligned redirect as a fetch fault.

Parameters:
- BASE_ADDR, 32'h0000_31B0, first program word address; reset PC.
- END_ADDR, 32'h0000_35AF, last byte of the program window. The last word is END_ADDR-3 = 0x35AC.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; highest priority.
- jump  in  1  redirect to jump_target.
- jump_target  in  32  jump destination.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  32  branch destination.
- pc_out  out  32  current fetch address, to the decoder's address_in.
- pc_plus4  out  32  sequential successor of pc_out, wrap applied.
- fetch_valid  out  1  pc_out holds a valid fetch address this cycle.
- wrapped  out  1  one-cycle pulse when the PC wrapped from 0x35AC to BASE_ADDR.
- fault  out  1  sticky fetch fault.

Behaviour:
- Reset (rst=0, async), all outputs forced immediately:
  - pc_out=BASE_ADDR, pc_plus4=BASE_ADDR+4.
  - fetch_valid=0, wrapped=0, fault=0.
  - state=BOOT.
- States: BOOT, RUN, FAULT.
  - BOOT: exactly one cycle after rst deasserts. pc_out=BASE_ADDR, fetch_valid=0, all inputs ignored. Next state is RUN.
  - RUN: fetch_valid=1. PC update on each rising edge uses this priority:
    1. stall=1: PC held. jump/branch_taken are ignored, and the requester must hold them until stall drops.
    2. jump=1: PC <= jump_target, if legal.
    3. branch_taken=1: PC <= branch_target, if legal.
    4. Otherwise: PC <= pc_plus4.
  - Legal target: BASE_ADDR <= t <= END_ADDR-3 and t[1:0]==0 (alignment rule subject to the optional feature).
  - Illegal taken target: PC does not change, state goes to FAULT, and fault rises on the same edge.
  - FAULT: pc_out frozen at the last legal PC, fetch_valid=0, fault=1. All inputs ignored until rst.
- Wrap-around:
  - pc_plus4 is BASE_ADDR when pc_out==END_ADDR-3, otherwise pc_out+4 (unsigned 32-bit).
  - wrapped=1 for the single cycle following an edge that took the wrapping increment.
  - Redirects never assert wrapped.
- Simultaneous events:
  - jump and branch_taken together: jump wins; the branch is dropped silently.
  - stall with an illegal target: no fault, because the target is not evaluated while stalled.
- Latency: a redirect presented in cycle N appears on pc_out in cycle N+1.
- Reset mid-operation: rst overrides every state; the sequence restarts at BOOT.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: a target with t[1:0]!=0 is illegal and triggers FAULT.
- Undefined: target bits [1:0] are forced to 2'b00 before the range check, and misalignment never faults.
- Range checking is always present.

Decomposition:
- Package mips_fetch_pkg holds:
  - the fetch_state_t enum (BOOT, RUN, FAULT);
  - PROG_BASE_ADDR = 32'h31B0 and PROG_END_ADDR = 32'h35AF;
  - PROG_LAST_WORD = PROG_END_ADDR-3.
  These constants are shared with the program-memory address decoder.
- One sub-module, pc_target_check: combinational. Input is the target; outputs are legal and the aligned target. It is instantiated twice, once for jump_target and once for branch_target.

Test Plan:
- Reset then release: cycle 0 shows pc_out=0x31B0 with fetch_valid=0. The next cycle shows fetch_valid=1 and pc_out=0x31B0, then 0x31B4, 0x31B8 on consecutive cycles.
- Free run to the top: after 255 increments from BASE, pc_out=0x35AC. On the next edge pc_out=0x31B0 and wrapped pulses for exactly one cycle.
- Stall plus redirect at pc=0x3200, with stall=1 for 3 cycles and jump=1 to 0x3300 throughout: pc_out stays 0x3200 for 3 cycles. Stall drops, and the next cycle shows pc_out=0x3300.
- jump=1 to 0x3400 and branch_taken=1 to 0x3280 in the same cycle: pc_out=0x3400 next cycle.
- branch_target=0x35B0 (above the window): fault=1 and fetch_valid=0, pc_out frozen at its prior value. Later inputs have no effect. rst low returns pc_out to 0x31B0 with fault=0.
- jump_target=0x3202:
  - With FETCH_ALIGN_CHECK_EN: fault=1.
  - Without it: pc_out=0x3200 next cycle and fault stays 0.
